// File: rtl/midi_transmitter_if.sv
// Event handshake between a note-event source and the MIDI transmitter.
// The source drives the event fields and VALID; the transmitter answers with READY.
interface midi_transmitter_if;
   logic       EVENT_VALID;
   logic       EVENT_READY;
   logic       EVENT_NOTE_ON;
   logic [3:0] EVENT_CHANNEL;
   logic [6:0] EVENT_NOTE;
   logic [6:0] EVENT_VELOCITY;

   modport master (
      output EVENT_VALID,
      output EVENT_NOTE_ON,
      output EVENT_CHANNEL,
      output EVENT_NOTE,
      output EVENT_VELOCITY,
      input  EVENT_READY
   );

   modport slave (
      input  EVENT_VALID,
      input  EVENT_NOTE_ON,
      input  EVENT_CHANNEL,
      input  EVENT_NOTE,
      input  EVENT_VELOCITY,
      output EVENT_READY
   );
endinterface

// File: rtl/midi_transmitter.sv
// Serialises Note On / Note Off events into 3-byte MIDI messages (8N1, LSB first).
// Define MIDI_TX_RUNNING_STATUS_EN to omit a status byte repeated from the last completed message.
module midi_transmitter #(
   parameter int CLKS_PER_BIT = 1600
) (
   input  logic                CLOCK_50,
   input  logic                RESET,
   midi_transmitter_if.slave   evt,
   output logic                MIDI_TX,
   output logic                BUSY
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [2:0]       bit_idx_reg, bit_idx_next;
   logic [1:0]       byte_idx_reg, byte_idx_next;
   logic [7:0]       status_reg, status_next;
   logic [7:0]       note_reg, note_next;
   logic [7:0]       vel_reg, vel_next;
   logic             tx_reg, tx_next;

   logic             accept;
   logic             bit_done;
   logic [2:0]       bit_inc;
   logic [7:0]       new_status;
   logic [7:0]       cur_byte;
   logic [1:0]       first_byte;

`ifdef MIDI_TX_RUNNING_STATUS_EN
   logic [7:0]       last_status_reg, last_status_next;
   logic             last_valid_reg, last_valid_next;

   // A repeated status is only skipped when the stored one came from a finished message.
   assign first_byte = (last_valid_reg && (last_status_reg == new_status)) ? 2'd1 : 2'd0;
`else
   assign first_byte = 2'd0;
`endif

   assign accept     = evt.EVENT_VALID && evt.EVENT_READY;
   assign bit_done   = (cnt_reg == CNT_MAX);
   assign bit_inc    = bit_idx_reg + 3'd1;
   assign new_status = {(evt.EVENT_NOTE_ON ? 4'h9 : 4'h8), evt.EVENT_CHANNEL};

   // READY is suppressed while RESET is held so nothing can be accepted during reset.
   assign evt.EVENT_READY = (state_reg == IDLE) && !RESET;
   assign BUSY            = (state_reg != IDLE);
   assign MIDI_TX         = tx_reg;

   always_comb begin
      cur_byte = 8'hFF;
      case (byte_idx_reg)
         2'd0:    cur_byte = status_reg;
         2'd1:    cur_byte = note_reg;
         2'd2:    cur_byte = vel_reg;
         default: cur_byte = 8'hFF;
      endcase
   end

   always_comb begin
      state_next    = state_reg;
      bit_idx_next  = bit_idx_reg;
      byte_idx_next = byte_idx_reg;
      status_next   = status_reg;
      note_next     = note_reg;
      vel_next      = vel_reg;
      tx_next       = tx_reg;
      cnt_next      = (state_reg == IDLE || bit_done) ? '0 : cnt_reg + CNT_W'(1);
`ifdef MIDI_TX_RUNNING_STATUS_EN
      last_status_next = last_status_reg;
      last_valid_next  = last_valid_reg;
`endif

      case (state_reg)
         IDLE: begin
            tx_next = 1'b1;
            if (accept) begin
               status_next   = new_status;
               note_next     = {1'b0, evt.EVENT_NOTE};
               vel_next      = {1'b0, evt.EVENT_VELOCITY};
               byte_idx_next = first_byte;
               bit_idx_next  = 3'd0;
               state_next    = START;
               tx_next       = 1'b0;
            end
         end
         START: begin
            if (bit_done) begin
               state_next   = DATA;
               bit_idx_next = 3'd0;
               tx_next      = cur_byte[0];
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_idx_reg == 3'd7) begin
                  state_next = STOP;
                  tx_next    = 1'b1;
               end else begin
                  bit_idx_next = bit_inc;
                  tx_next      = cur_byte[bit_inc];
               end
            end
         end
         STOP: begin
            if (bit_done) begin
               bit_idx_next = 3'd0;
               if (byte_idx_reg == 2'd2) begin
                  state_next    = IDLE;
                  byte_idx_next = 2'd0;
                  tx_next       = 1'b1;
`ifdef MIDI_TX_RUNNING_STATUS_EN
                  last_status_next = status_reg;
                  last_valid_next  = 1'b1;
`endif
               end else begin
                  // Next byte starts straight after the stop bit.
                  state_next    = START;
                  byte_idx_next = byte_idx_reg + 2'd1;
                  tx_next       = 1'b0;
               end
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         bit_idx_reg  <= 3'd0;
         byte_idx_reg <= 2'd0;
         status_reg   <= 8'h00;
         note_reg     <= 8'h00;
         vel_reg      <= 8'h00;
         tx_reg       <= 1'b1;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         bit_idx_reg  <= bit_idx_next;
         byte_idx_reg <= byte_idx_next;
         status_reg   <= status_next;
         note_reg     <= note_next;
         vel_reg      <= vel_next;
         tx_reg       <= tx_next;
      end
   end

`ifdef MIDI_TX_RUNNING_STATUS_EN
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         last_status_reg <= 8'h00;
         last_valid_reg  <= 1'b0;
      end else begin
         last_status_reg <= last_status_next;
         last_valid_reg  <= last_valid_next;
      end
   end
`endif

endmodule

// File: doc/midi_transmitter.md
MIDI_TRANSMITTER -- requirements
Module: midi_transmitter

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 1600, giving the CLOCK_50 cycles per MIDI bit (50 MHz / 31250 baud).
REQ-002 SHALL provide CLOCK_50  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL provide RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL provide EVENT_VALID  input  1  an event is offered.
REQ-005 SHALL provide EVENT_READY  output  1  the block can accept an event this cycle.
REQ-006 SHALL provide EVENT_NOTE_ON  input  1  1 = Note On, 0 = Note Off.
REQ-007 SHALL provide EVENT_CHANNEL  input  4  MIDI channel 0-15.
REQ-008 SHALL provide EVENT_NOTE  input  7  note number.
REQ-009 SHALL provide EVENT_VELOCITY  input  7  velocity.
REQ-010 SHALL provide MIDI_TX  output  1  serial MIDI line; idle level is high.
REQ-011 SHALL provide BUSY  output  1  a message is in progress.

Function
REQ-012 An event SHALL be accepted on a cycle where EVENT_VALID and EVENT_READY are both 1; the block SHALL latch all EVENT_* fields on that cycle.
REQ-013 EVENT_READY SHALL be 1 only in state IDLE and SHALL drop the cycle after acceptance.
REQ-014 The status byte SHALL be 0x90|channel for Note On and 0x80|channel for Note Off.
REQ-015 The message SHALL be sent as status, then {0,note}, then {0,velocity}; velocity 0 SHALL be sent unchanged.
REQ-016 Each byte frame SHALL be: start bit 0, 8 data bits LSB first, stop bit 1; every bit lasts exactly CLKS_PER_BIT cycles.
REQ-017 The state machine SHALL have four states: IDLE, START, DATA, STOP.
- IDLE -> START on acceptance.
- START -> DATA after 1 bit time.
- DATA -> STOP after 8 bit times.
- STOP -> START (next byte) or IDLE (last byte) after 1 bit time.
REQ-018 Bytes within a message SHALL be back-to-back, with no idle gap beyond the stop bit.
REQ-019 MIDI_TX SHALL be registered; the start bit SHALL appear on the cycle after acceptance.
REQ-020 A full 3-byte message SHALL occupy exactly 30*CLKS_PER_BIT cycles of MIDI_TX.
REQ-021 EVENT_READY SHALL return to 1 on the first cycle after the final stop bit completes.
REQ-022 BUSY SHALL be 1 from the cycle after acceptance through the end of the final stop bit, and SHALL equal ~EVENT_READY.
REQ-023 The bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap; the bit index SHALL count 0..7; the byte index SHALL count 0..2.
REQ-024 Changes on EVENT_* inputs while BUSY SHALL have no effect on the message in flight.

Reset
REQ-025 While RESET is 1, the block SHALL set MIDI_TX=1, EVENT_READY=0, BUSY=0, state=IDLE, all counters=0, and the last-status register to invalid.
REQ-026 A RESET asserted mid-frame SHALL abort the message; MIDI_TX SHALL be high on the next cycle and no partial byte SHALL be resumed.
REQ-027 EVENT_READY SHALL be 1 on the first cycle after RESET deasserts.

Configuration
REQ-028 With macro MIDI_TX_RUNNING_STATUS_EN defined:
- The block SHALL keep the status byte of the last completed message.
- If a new status equals the stored value and the stored value is valid, the status byte SHALL be omitted: 2 bytes, 20*CLKS_PER_BIT cycles.
- The stored status SHALL update only when a message completes.
- Reset SHALL invalidate the stored status.
REQ-029 Without MIDI_TX_RUNNING_STATUS_EN, the status byte SHALL always be sent and the last-status register SHALL NOT exist.

Verification (CLKS_PER_BIT=16)
REQ-030 Reset, then Note On ch0 note 0x3C vel 0x64 -> MIDI_TX frames 0x90, 0x3C, 0x64 LSB first; 480 cycles; EVENT_READY high at cycle 481.
REQ-031 Note Off ch15 note 0x7F vel 0x00 -> bytes 0x8F, 0x7F, 0x00; each stop bit high for 16 cycles.
REQ-032 Assert RESET at cycle 100 of a message -> MIDI_TX=1 on the next cycle; the next event sends its full status byte.
REQ-033 EVENT_VALID held high with changing fields during a message -> only the first event's bytes are transmitted; the next event is accepted on the first READY cycle.
REQ-034 With MIDI_TX_RUNNING_STATUS_EN: two Note On ch3 events -> 0x93,n,v then n,v only (320 cycles); a following Note Off ch3 -> 0x83 is sent. Without the macro, the second event is sent as 0x93,n,v.
